csr_file: RTL and testbench

// - Machine/user CSR responder: answers the combinational CSR request issued by the SYSTEM exec unit (read-old/modify/write).
// - Holds privilege mode, trap state (mstatus/mepc/mcause/mtval/mtvec), interrupt enables and the cycle/instret counters.
// - Applies trap entry and xRET state updates; feeds mstatus/mepc/privilege back to exec.

---
 rtl/csr_file.sv | 249 ++++++++++++++++++++++++
 tb/tb_csr_file.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine/user CSR responder for the SYSTEM exec unit.
// Answers a combinational read-old/modify/write request each cycle.
// The write lands on the following clock edge.
// Also holds privilege mode, trap state, interrupt enables and the 64-bit
// cycle/instret counters.
// Trap entry and xRET updates take precedence over software CSR writes.

`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 64
`endif

`ifndef ALEN
`define ALEN 64
`endif

module csr_file #(
    parameter logic [63:0] HARTID      = 64'd0,
    parameter logic [63:0] MISA_VAL    = 64'h8000_0000_0014_1100,
    parameter logic [63:0] MTVEC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               exec_csr_instr_valid,
    input  logic [11:0]        exec_csr_addr,
    input  logic [2:0]         exec_csr_funct3,
    input  logic [4:0]         exec_csr_rd,
    input  logic [4:0]         exec_csr_rs1_uimm,
    input  logic [`XLEN-1:0]   exec_csr_rs1_data,
    output logic               exec_csr_exception,
    output logic [3:0]         exec_csr_trap_cause,
    output logic [`XLEN-1:0]   exec_csr_result,

    input  logic               xret_valid,
    input  logic [`XLEN-1:0]   xret_new_mstatus,
    input  logic [1:0]         xret_new_privilege_mode,

    input  logic               trap_valid,
    input  logic               trap_is_interrupt,
    input  logic [3:0]         trap_cause,
    input  logic [`ALEN-1:0]   trap_pc,
    input  logic [`XLEN-1:0]   trap_tval,

    input  logic               instret_inc,
    input  logic               irq_software,
    input  logic               irq_timer,
    input  logic               irq_external,

    output logic [1:0]         privilege_mode,
    output logic [`XLEN-1:0]   mstatus,
    output logic [`ALEN-1:0]   mepc,
    output logic [`XLEN-1:0]   mtvec,
    output logic               interrupt_pending
);

    // The counters and masks below are laid out for a 64-bit hart only.
    if (`XLEN != 64) begin : g_xlen_check
        $error("csr_file supports only XLEN == 64");
    end

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [1:0]  PRIV_M            = 2'b11;
    localparam logic [3:0]  EXC_ILLEGAL_INSTR = 4'd2;
    localparam logic [63:0] MIE_MASK          = 64'h0000_0000_0000_0888;

    logic [1:0]  priv_q;
    logic [63:0] mstatus_q;
    logic [63:0] mepc_q;
    logic [63:0] mcause_q;
    logic [63:0] mtval_q;
    logic [63:0] mie_q;
    logic [63:0] mtvec_q;
    logic [63:0] mscratch_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [63:0] mip_val;
    logic [63:0] csr_rdata;
    logic        csr_implemented;
    logic [63:0] csr_operand;
    logic [63:0] csr_new;
    logic [63:0] mstatus_wval;
    logic        funct3_legal;
    logic        write_req;
    logic        priv_fail;
    logic        read_only_fail;
    logic        csr_illegal;
    logic        csr_we;
    logic        unused_rd;

    // The destination register only matters to the exec unit.
    assign unused_rd = ^exec_csr_rd;

    assign mip_val = {52'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};

    // Select the pre-write CSR value and flag addresses that do not exist.
    always_comb begin
        csr_rdata       = '0;
        csr_implemented = 1'b1;
        case (exec_csr_addr)
            ADDR_MSTATUS:   csr_rdata = mstatus_q;
            ADDR_MISA:      csr_rdata = MISA_VAL;
            ADDR_MIE:       csr_rdata = mie_q;
            ADDR_MTVEC:     csr_rdata = mtvec_q;
            ADDR_MSCRATCH:  csr_rdata = mscratch_q;
            ADDR_MEPC:      csr_rdata = mepc_q;
            ADDR_MCAUSE:    csr_rdata = mcause_q;
            ADDR_MTVAL:     csr_rdata = mtval_q;
            ADDR_MIP:       csr_rdata = mip_val;
            ADDR_MCYCLE:    csr_rdata = mcycle_q;
            ADDR_MINSTRET:  csr_rdata = minstret_q;
            ADDR_CYCLE:     csr_rdata = mcycle_q;
            ADDR_INSTRET:   csr_rdata = minstret_q;
            ADDR_MVENDORID: csr_rdata = '0;
            ADDR_MARCHID:   csr_rdata = '0;
            ADDR_MIMPID:    csr_rdata = '0;
            ADDR_MHARTID:   csr_rdata = HARTID;
            default:        csr_implemented = 1'b0;
        endcase
    end

    // Build the modified value from the operand; set/clear use the old value.
    always_comb begin
        csr_operand = exec_csr_funct3[2] ? {59'b0, exec_csr_rs1_uimm} : exec_csr_rs1_data;
        case (exec_csr_funct3[1:0])
            2'b01:   csr_new = csr_operand;
            2'b10:   csr_new = csr_rdata | csr_operand;
            2'b11:   csr_new = csr_rdata & ~csr_operand;
            default: csr_new = csr_rdata;
        endcase
    end

    // Only MIE, MPIE and MPP are writable; the reserved MPP encoding falls back to U.
    always_comb begin
        mstatus_wval        = '0;
        mstatus_wval[3]     = csr_new[3];
        mstatus_wval[7]     = csr_new[7];
        mstatus_wval[12:11] = (csr_new[12:11] == 2'b10) ? 2'b00 : csr_new[12:11];
    end

    // Decide legality and whether the request actually writes the CSR.
    always_comb begin
        funct3_legal   = (exec_csr_funct3[1:0] != 2'b00);
        write_req      = exec_csr_instr_valid && funct3_legal &&
                         ((exec_csr_funct3[1:0] == 2'b01) || (exec_csr_rs1_uimm != 5'd0));
        priv_fail      = (exec_csr_addr[9:8] > priv_q);
        read_only_fail = write_req && (exec_csr_addr[11:10] == 2'b11);
        csr_illegal    = exec_csr_instr_valid &&
                         (!funct3_legal || !csr_implemented || priv_fail || read_only_fail);
        csr_we         = write_req && !csr_illegal && !trap_valid && !xret_valid;
    end

    assign exec_csr_exception  = csr_illegal;
    assign exec_csr_trap_cause = csr_illegal ? EXC_ILLEGAL_INSTR : 4'd0;
    assign exec_csr_result     = csr_rdata;

    assign privilege_mode    = priv_q;
    assign mstatus           = mstatus_q;
    assign mepc              = mepc_q;
    assign mtvec             = mtvec_q;
    assign interrupt_pending = ((priv_q != PRIV_M) || mstatus_q[3]) && (|(mie_q & mip_val));

    // Privilege and mstatus: trap entry beats xRET, which beats a CSR write.
    always_ff @(posedge clk) begin
        if (rst) begin
            priv_q    <= PRIV_M;
            mstatus_q <= '0;
        end else if (trap_valid) begin
            priv_q             <= PRIV_M;
            mstatus_q[7]       <= mstatus_q[3];
            mstatus_q[3]       <= 1'b0;
            mstatus_q[12:11]   <= priv_q;
        end else if (xret_valid) begin
            priv_q    <= xret_new_privilege_mode;
            mstatus_q <= xret_new_mstatus;
        end else if (csr_we && (exec_csr_addr == ADDR_MSTATUS)) begin
            mstatus_q <= mstatus_wval;
        end
    end

    // Trap record registers, captured on trap entry or written by software.
    always_ff @(posedge clk) begin
        if (rst) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap_valid) begin
            mepc_q   <= trap_pc & ~64'd3;
            mcause_q <= {trap_is_interrupt, 59'b0, trap_cause};
            mtval_q  <= trap_tval;
        end else if (csr_we) begin
            if (exec_csr_addr == ADDR_MEPC)   mepc_q   <= csr_new & ~64'd3;
            if (exec_csr_addr == ADDR_MCAUSE) mcause_q <= csr_new;
            if (exec_csr_addr == ADDR_MTVAL)  mtval_q  <= csr_new;
        end
    end

    // Software-only registers: interrupt enables, trap vector and scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= '0;
            mtvec_q    <= {MTVEC_RESET[63:2], 2'b00};
            mscratch_q <= '0;
        end else if (csr_we) begin
            if (exec_csr_addr == ADDR_MIE)      mie_q      <= csr_new & MIE_MASK;
            if (exec_csr_addr == ADDR_MTVEC)    mtvec_q    <= csr_new & ~64'd3;
            if (exec_csr_addr == ADDR_MSCRATCH) mscratch_q <= csr_new;
        end
    end

    // Free-running counters; a software write in the same cycle replaces the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && (exec_csr_addr == ADDR_MCYCLE)) begin
                mcycle_q <= csr_new;
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end
            if (csr_we && (exec_csr_addr == ADDR_MINSTRET)) begin
                minstret_q <= csr_new;
            end else if (instret_inc) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed-vector bench for csr_file with hand-computed expectations.

`timescale 1ns/1ps

module tb_csr_file;

    logic        clk;
    logic        rst;
    logic        exec_csr_instr_valid;
    logic [11:0] exec_csr_addr;
    logic [2:0]  exec_csr_funct3;
    logic [4:0]  exec_csr_rd;
    logic [4:0]  exec_csr_rs1_uimm;
    logic [63:0] exec_csr_rs1_data;
    logic        exec_csr_exception;
    logic [3:0]  exec_csr_trap_cause;
    logic [63:0] exec_csr_result;
    logic        xret_valid;
    logic [63:0] xret_new_mstatus;
    logic [1:0]  xret_new_privilege_mode;
    logic        trap_valid;
    logic        trap_is_interrupt;
    logic [3:0]  trap_cause;
    logic [63:0] trap_pc;
    logic [63:0] trap_tval;
    logic        instret_inc;
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [1:0]  privilege_mode;
    logic [63:0] mstatus;
    logic [63:0] mepc;
    logic [63:0] mtvec;
    logic        interrupt_pending;

    int total;
    int bad;

    csr_file #(
        .HARTID(64'd3),
        .MISA_VAL(64'h8000_0000_0014_1100),
        .MTVEC_RESET(64'h0000_0000_8000_0103)
    ) dut (
        .clk(clk),
        .rst(rst),
        .exec_csr_instr_valid(exec_csr_instr_valid),
        .exec_csr_addr(exec_csr_addr),
        .exec_csr_funct3(exec_csr_funct3),
        .exec_csr_rd(exec_csr_rd),
        .exec_csr_rs1_uimm(exec_csr_rs1_uimm),
        .exec_csr_rs1_data(exec_csr_rs1_data),
        .exec_csr_exception(exec_csr_exception),
        .exec_csr_trap_cause(exec_csr_trap_cause),
        .exec_csr_result(exec_csr_result),
        .xret_valid(xret_valid),
        .xret_new_mstatus(xret_new_mstatus),
        .xret_new_privilege_mode(xret_new_privilege_mode),
        .trap_valid(trap_valid),
        .trap_is_interrupt(trap_is_interrupt),
        .trap_cause(trap_cause),
        .trap_pc(trap_pc),
        .trap_tval(trap_tval),
        .instret_inc(instret_inc),
        .irq_software(irq_software),
        .irq_timer(irq_timer),
        .irq_external(irq_external),
        .privilege_mode(privilege_mode),
        .mstatus(mstatus),
        .mepc(mepc),
        .mtvec(mtvec),
        .interrupt_pending(interrupt_pending)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        exec_csr_instr_valid    = 1'b0;
        exec_csr_addr           = 12'h000;
        exec_csr_funct3         = 3'b000;
        exec_csr_rd             = 5'd0;
        exec_csr_rs1_uimm       = 5'd0;
        exec_csr_rs1_data       = 64'd0;
        xret_valid              = 1'b0;
        xret_new_mstatus        = 64'd0;
        xret_new_privilege_mode = 2'b00;
        trap_valid              = 1'b0;
        trap_is_interrupt       = 1'b0;
        trap_cause              = 4'd0;
        trap_pc                 = 64'd0;
        trap_tval               = 64'd0;
        instret_inc             = 1'b0;
        irq_software            = 1'b0;
        irq_timer               = 1'b0;
        irq_external            = 1'b0;
    endtask

    // Starts a new cycle at the falling edge and presents one CSR request.
    task automatic drive_csr(input logic [11:0] addr, input logic [2:0] f3,
                             input logic [4:0] uimm, input logic [63:0] data);
        @(negedge clk);
        idle_inputs();
        exec_csr_instr_valid = 1'b1;
        exec_csr_addr        = addr;
        exec_csr_funct3      = f3;
        exec_csr_rd          = 5'd1;
        exec_csr_rs1_uimm    = uimm;
        exec_csr_rs1_data    = data;
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (privilege_mode !== 2'b11) begin bad++; $display("[TB] FAIL reset_priv: got %0h expected 3", privilege_mode); end
        total++; if (mstatus !== 64'd0) begin bad++; $display("[TB] FAIL reset_mstatus: got %h expected 0", mstatus); end
        total++; if (mepc !== 64'd0) begin bad++; $display("[TB] FAIL reset_mepc: got %h expected 0", mepc); end
        total++; if (mtvec !== 64'h8000_0100) begin bad++; $display("[TB] FAIL reset_mtvec: got %h expected 80000100", mtvec); end
        total++; if (interrupt_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq_pending: got %b expected 0", interrupt_pending); end
        drive_csr(12'h300, 3'b010, 5'd0, 64'hFFFF);
        total++; if (exec_csr_result !== 64'd0) begin bad++; $display("[TB] FAIL reset_read_mstatus: got %h expected 0", exec_csr_result); end
        total++; if (exec_csr_exception !== 1'b0) begin bad++; $display("[TB] FAIL reset_read_exc: got %b expected 0", exec_csr_exception); end
        drive_csr(12'h305, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'h8000_0100) begin bad++; $display("[TB] FAIL reset_read_mtvec: got %h expected 80000100", exec_csr_result); end
    endtask

    task automatic test_mscratch();
        drive_csr(12'h340, 3'b001, 5'd2, 64'hDEAD_BEEF);
        total++; if (exec_csr_result !== 64'd0) begin bad++; $display("[TB] FAIL mscratch_rw_old: got %h expected 0", exec_csr_result); end
        drive_csr(12'h340, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hDEAD_BEEF) begin bad++; $display("[TB] FAIL mscratch_readback: got %h expected deadbeef", exec_csr_result); end
        drive_csr(12'h340, 3'b110, 5'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        total++; if (exec_csr_result !== 64'hDEAD_BEEF) begin bad++; $display("[TB] FAIL mscratch_rsi_old: got %h expected deadbeef", exec_csr_result); end
        drive_csr(12'h340, 3'b111, 5'h0F, 64'd0);
        total++; if (exec_csr_result !== 64'hDEAD_BEFF) begin bad++; $display("[TB] FAIL mscratch_rsi_new: got %h expected deadbeff", exec_csr_result); end
        drive_csr(12'h340, 3'b011, 5'd0, 64'hFFFF);
        total++; if (exec_csr_result !== 64'hDEAD_BEF0) begin bad++; $display("[TB] FAIL mscratch_rci_new: got %h expected deadbef0", exec_csr_result); end
        drive_csr(12'h340, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hDEAD_BEF0) begin bad++; $display("[TB] FAIL mscratch_rc_x0_nowrite: got %h expected deadbef0", exec_csr_result); end
    endtask

    task automatic test_masks();
        drive_csr(12'h300, 3'b001, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        total++; if (exec_csr_result !== 64'd0) begin bad++; $display("[TB] FAIL mstatus_rw_old: got %h expected 0", exec_csr_result); end
        drive_csr(12'h300, 3'b011, 5'd1, 64'h8);
        total++; if (exec_csr_result !== 64'h1888) begin bad++; $display("[TB] FAIL mstatus_masked: got %h expected 1888", exec_csr_result); end
        drive_csr(12'h300, 3'b001, 5'd1, 64'h1000);
        total++; if (exec_csr_result !== 64'h1880) begin bad++; $display("[TB] FAIL mstatus_rc: got %h expected 1880", exec_csr_result); end
        drive_csr(12'h304, 3'b001, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        total++; if (mstatus !== 64'd0) begin bad++; $display("[TB] FAIL mstatus_mpp10: got %h expected 0", mstatus); end
        drive_csr(12'h305, 3'b001, 5'd1, 64'h2003);
        total++; if (exec_csr_result !== 64'h8000_0100) begin bad++; $display("[TB] FAIL mtvec_rw_old: got %h expected 80000100", exec_csr_result); end
        drive_csr(12'h304, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'h888) begin bad++; $display("[TB] FAIL mie_mask: got %h expected 888", exec_csr_result); end
        total++; if (mtvec !== 64'h2000) begin bad++; $display("[TB] FAIL mtvec_mask: got %h expected 2000", mtvec); end
        drive_csr(12'h341, 3'b001, 5'd1, 64'h1237);
        drive_csr(12'h301, 3'b001, 5'd1, 64'd0);
        total++; if (mepc !== 64'h1234) begin bad++; $display("[TB] FAIL mepc_mask: got %h expected 1234", mepc); end
        total++; if (exec_csr_result !== 64'h8000_0000_0014_1100 || exec_csr_exception !== 1'b0) begin bad++; $display("[TB] FAIL misa_write: got %h exc %b expected 8000000000141100 exc 0", exec_csr_result, exec_csr_exception); end
        drive_csr(12'h301, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'h8000_0000_0014_1100) begin bad++; $display("[TB] FAIL misa_unchanged: got %h expected 8000000000141100", exec_csr_result); end
        drive_csr(12'h344, 3'b001, 5'd1, 64'hFFFF);
        irq_timer = 1'b1; irq_software = 1'b1; #1;
        total++; if (exec_csr_result !== 64'h88 || exec_csr_exception !== 1'b0) begin bad++; $display("[TB] FAIL mip_read: got %h exc %b expected 88 exc 0", exec_csr_result, exec_csr_exception); end
        drive_csr(12'hF14, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'd3) begin bad++; $display("[TB] FAIL mhartid: got %h expected 3", exec_csr_result); end
        drive_csr(12'hF12, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'd0 || exec_csr_exception !== 1'b0) begin bad++; $display("[TB] FAIL marchid: got %h exc %b expected 0 exc 0", exec_csr_result, exec_csr_exception); end
        drive_csr(12'hF14, 3'b001, 5'd0, 64'd0);
        total++; if (exec_csr_exception !== 1'b1 || exec_csr_trap_cause !== 4'd2) begin bad++; $display("[TB] FAIL mhartid_write: got exc %b cause %0d expected exc 1 cause 2", exec_csr_exception, exec_csr_trap_cause); end
        drive_csr(12'h7C0, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_exception !== 1'b1) begin bad++; $display("[TB] FAIL unimpl_addr: got %b expected 1", exec_csr_exception); end
        drive_csr(12'hC00, 3'b001, 5'd1, 64'd0);
        total++; if (exec_csr_exception !== 1'b1) begin bad++; $display("[TB] FAIL cycle_write: got %b expected 1", exec_csr_exception); end
    endtask

    task automatic test_privilege();
        idle_cycle();
        xret_valid = 1'b1; xret_new_mstatus = 64'h8; xret_new_privilege_mode = 2'b00;
        idle_cycle();
        total++; if (privilege_mode !== 2'b00 || mstatus !== 64'h8) begin bad++; $display("[TB] FAIL xret_to_u: got priv %0h mstatus %h expected priv 0 mstatus 8", privilege_mode, mstatus); end
        drive_csr(12'h300, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_exception !== 1'b1 || exec_csr_trap_cause !== 4'd2) begin bad++; $display("[TB] FAIL u_read_mstatus: got exc %b cause %0d expected exc 1 cause 2", exec_csr_exception, exec_csr_trap_cause); end
        drive_csr(12'h300, 3'b001, 5'd1, 64'd0);
        drive_csr(12'hC00, 3'b010, 5'd0, 64'd0);
        total++; if (mstatus !== 64'h8) begin bad++; $display("[TB] FAIL u_write_dropped: got %h expected 8", mstatus); end
        total++; if (exec_csr_exception !== 1'b0) begin bad++; $display("[TB] FAIL u_read_cycle: got %b expected 0", exec_csr_exception); end
        drive_csr(12'hB00, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_exception !== 1'b1) begin bad++; $display("[TB] FAIL u_read_mcycle: got %b expected 1", exec_csr_exception); end
        idle_cycle();
        irq_timer = 1'b1; #1;
        total++; if (interrupt_pending !== 1'b1) begin bad++; $display("[TB] FAIL u_irq_pending: got %b expected 1", interrupt_pending); end
    endtask

    task automatic test_trap();
        drive_csr(12'h340, 3'b001, 5'd1, 64'h1111);
        trap_valid = 1'b1; trap_cause = 4'd2; trap_pc = 64'h1002; trap_tval = 64'hBAD;
        drive_csr(12'h342, 3'b010, 5'd0, 64'd0);
        total++; if (privilege_mode !== 2'b11 || mepc !== 64'h1000 || mstatus !== 64'h80) begin bad++; $display("[TB] FAIL trap_u_state: got priv %0h mepc %h mstatus %h expected 3 1000 80", privilege_mode, mepc, mstatus); end
        total++; if (exec_csr_result !== 64'd2) begin bad++; $display("[TB] FAIL trap_u_mcause: got %h expected 2", exec_csr_result); end
        drive_csr(12'h343, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hBAD) begin bad++; $display("[TB] FAIL trap_u_mtval: got %h expected bad", exec_csr_result); end
        drive_csr(12'h340, 3'b001, 5'd1, 64'h1111);
        trap_valid = 1'b1; trap_is_interrupt = 1'b1; trap_cause = 4'd7; trap_pc = 64'h2000; #1;
        total++; if (exec_csr_exception !== 1'b0 || exec_csr_result !== 64'hDEAD_BEF0) begin bad++; $display("[TB] FAIL trap_m_comb: got %h exc %b expected deadbef0 exc 0", exec_csr_result, exec_csr_exception); end
        drive_csr(12'h340, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hDEAD_BEF0) begin bad++; $display("[TB] FAIL trap_m_write_dropped: got %h expected deadbef0", exec_csr_result); end
        total++; if (mstatus !== 64'h1800 || mepc !== 64'h2000) begin bad++; $display("[TB] FAIL trap_m_state: got mstatus %h mepc %h expected 1800 2000", mstatus, mepc); end
        drive_csr(12'h342, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'h8000_0000_0000_0007) begin bad++; $display("[TB] FAIL trap_m_mcause: got %h expected 8000000000000007", exec_csr_result); end
        drive_csr(12'h340, 3'b001, 5'd1, 64'h2222);
        xret_valid = 1'b1; xret_new_mstatus = 64'h88; xret_new_privilege_mode = 2'b11;
        drive_csr(12'h340, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hDEAD_BEF0 || mstatus !== 64'h88) begin bad++; $display("[TB] FAIL xret_over_write: got mscratch %h mstatus %h expected deadbef0 88", exec_csr_result, mstatus); end
        idle_cycle();
        trap_valid = 1'b1; trap_cause = 4'd3; trap_pc = 64'h3004;
        xret_valid = 1'b1; xret_new_mstatus = 64'd0; xret_new_privilege_mode = 2'b00;
        idle_cycle();
        total++; if (privilege_mode !== 2'b11 || mepc !== 64'h3004 || mstatus !== 64'h1880) begin bad++; $display("[TB] FAIL trap_over_xret: got priv %0h mepc %h mstatus %h expected 3 3004 1880", privilege_mode, mepc, mstatus); end
        irq_timer = 1'b1; #1;
        total++; if (interrupt_pending !== 1'b0) begin bad++; $display("[TB] FAIL m_irq_masked: got %b expected 0", interrupt_pending); end
    endtask

    task automatic test_counters();
        drive_csr(12'hB00, 3'b001, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        drive_csr(12'hB00, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("[TB] FAIL mcycle_written: got %h expected fffffffffffffffe", exec_csr_result); end
        drive_csr(12'hC00, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL mcycle_max: got %h expected ffffffffffffffff", exec_csr_result); end
        drive_csr(12'hB00, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'd0) begin bad++; $display("[TB] FAIL mcycle_wrap: got %h expected 0", exec_csr_result); end
        drive_csr(12'hB02, 3'b001, 5'd1, 64'd10);
        instret_inc = 1'b1;
        drive_csr(12'hB02, 3'b010, 5'd0, 64'd0);
        instret_inc = 1'b1; #1;
        total++; if (exec_csr_result !== 64'd10) begin bad++; $display("[TB] FAIL minstret_write_wins: got %0d expected 10", exec_csr_result); end
        drive_csr(12'hC02, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'd11) begin bad++; $display("[TB] FAIL minstret_inc: got %0d expected 11", exec_csr_result); end
        drive_csr(12'hB02, 3'b010, 5'd0, 64'd0);
        total++; if (exec_csr_result !== 64'd11) begin bad++; $display("[TB] FAIL minstret_hold: got %0d expected 11", exec_csr_result); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_mscratch();
        test_masks();
        test_privilege();
        test_trap();
        test_counters();
        idle_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
